bp_program_counter: RTL and testbench
=====================================

Name: bp_program_counter

Overview:
Parametrised fetch-stage program counter that extends the single-cycle PC with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. Each cycle it predicts the next fetch address from the current PC. It accepts redirects from the execute stage on misprediction and accepts BTB training from resolved branches. It sits between the pipeline hazard unit (Stall/Redirect) and instruction memory.

Parameters:
ADDR_W, 32, width of PC and all address/target buses
RESET_VEC, 32'h0000_0000, PC value loaded on reset
BTB_DEPTH, 8, number of BTB entries; power of two, 2..64
INSTR_BYTES, 4, sequential increment; power of two

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  asynchronous, active-low reset
Stall  input  1  hold PC (hazard / multicycle busy)
Redirect  input  1  execute-stage mispredict; load Redirect_Target
Redirect_Target  input  ADDR_W  correct next PC
Upd_En  input  1  train BTB with a resolved branch
Upd_PC  input  ADDR_W  PC of resolved branch
Upd_Target  input  ADDR_W  resolved branch target
Upd_Taken  input  1  resolved direction
PC  output  ADDR_W  current fetch address
PC_Plus_4  output  ADDR_W  PC + INSTR_BYTES, modulo 2^ADDR_W
Pred_Taken  output  1  prediction for current PC (travels down pipe)
Pred_Target  output  ADDR_W  predicted target for current PC

Behaviour:
- IDX_W = log2(BTB_DEPTH); OFF_W = log2(INSTR_BYTES). Index = PC[OFF_W+IDX_W-1:OFF_W]. Tag = PC[ADDR_W-1:OFF_W+IDX_W].
- Entry contents: valid (1), tag, target (ADDR_W), ctr (2-bit).
- Reset (Reset=0, asynchronous): PC=RESET_VEC, all valid=0, all ctr=2'b01, all targets/tags=0. The resulting outputs are PC_Plus_4=RESET_VEC+INSTR_BYTES, Pred_Taken=0, Pred_Target=0. Release is taken at the next rising CLK edge; no update occurs in the release cycle while Reset=0.
- Lookup is combinational on the current PC, with zero latency:
  - hit = valid[idx] & tag match.
  - Pred_Taken = hit & ctr[idx][1].
  - Pred_Target = target[idx] when hit, else 0.
- Next-PC priority at each rising edge:
  1. Redirect -> Redirect_Target. This overrides Stall.
  2. Stall -> hold PC.
  3. Pred_Taken -> Pred_Target.
  4. Otherwise -> PC_Plus_4.
- BTB training occurs at the rising edge when Upd_En=1, independent of Stall and Redirect. It is indexed by Upd_PC:
  - Tag hit, taken: ctr = min(ctr+1, 3); target = Upd_Target.
  - Tag hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate or replace the entry: valid=1, tag written, target=Upd_Target, ctr=2'b10.
  - Miss, not taken: no change.
- Same-cycle lookup and update on the same entry: the lookup uses pre-edge contents. The new contents are visible from the next cycle. There is no bypass.
- Wrap-around: PC_Plus_4 at PC=2^ADDR_W-INSTR_BYTES is 0.
- Low OFF_W bits of PC come only from RESET_VEC or targets. The block does not force alignment.
- Reset asserted mid-operation clears PC and the BTB immediately, regardless of Stall, Redirect, or Upd_En.

Test Plan:
1. Reset low then high, Stall=0, no updates -> PC sequence 0x0, 0x4, 0x8, 0xC; Pred_Taken=0 throughout.
2. Upd_En with Upd_PC=0x10, Upd_Target=0x40, Upd_Taken=1, then fetch reaches 0x10 -> Pred_Taken=1, Pred_Target=0x40, next PC=0x40.
3. Train 0x10 not-taken twice after case 2 -> ctr goes 10 -> 01 -> 00. Next visit to 0x10 gives Pred_Taken=0 and next PC=0x14. Three further taken updates saturate ctr at 11.
4. Alias: train 0x10 taken, then 0x30 taken (BTB_DEPTH=8) -> entry replaced. At PC=0x10, hit=0 and next PC=0x14.
5. Stall=1 and Redirect=1 with Redirect_Target=0x100 in the same cycle -> PC=0x100. Stall alone for 3 cycles -> PC constant.
6. Reset asserted asynchronously mid-cycle with PC=0x200 and a trained BTB -> PC=RESET_VEC immediately. After release, no previously trained address predicts taken.

Source files
------------

// File: rtl/bp_program_counter.sv
// bp_program_counter
//   Fetch-stage program counter with a direct-mapped branch target buffer
//   and 2-bit saturating direction counters. Each cycle the current PC is
//   looked up in the BTB (combinational, zero latency) and the next fetch
//   address is chosen from redirect / stall / prediction / sequential.
//   Resolved branches train the BTB through the Upd_* port.
//
// Ports
//   CLK, Reset          clock (rising edge), async active-low reset
//   Stall               hold PC
//   Redirect            load Redirect_Target (wins over Stall)
//   Upd_En/PC/Target/Taken  BTB training from a resolved branch
//   PC, PC_Plus_4       current fetch address and its sequential successor
//   Pred_Taken/Target   prediction for the current PC

// One BTB entry. Training is applied when Upd_Sel (index match & Upd_En).
module bp_program_counter_btb_entry #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 27
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Upd_Sel,
  input  logic [TAG_W-1:0]  Upd_Tag,
  input  logic [ADDR_W-1:0] Upd_Target,
  input  logic              Upd_Taken,
  output logic              ent_valid,
  output logic [TAG_W-1:0]  ent_tag,
  output logic [ADDR_W-1:0] ent_target,
  output logic [1:0]        ent_ctr
);

  logic upd_hit;
  assign upd_hit = ent_valid && (ent_tag == Upd_Tag);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ent_valid  <= 1'b0;
      ent_tag    <= '0;
      ent_target <= '0;
      ent_ctr    <= 2'b01;
    end else if (Upd_Sel) begin
      if (upd_hit) begin
        if (Upd_Taken) begin
          if (ent_ctr != 2'b11) ent_ctr <= ent_ctr + 2'b01;
          ent_target <= Upd_Target;
        end else begin
          // not-taken keeps the old target so a later re-warm reuses it
          if (ent_ctr != 2'b00) ent_ctr <= ent_ctr - 2'b01;
        end
      end else if (Upd_Taken) begin
        // allocate/replace on a taken miss; start weakly taken
        ent_valid  <= 1'b1;
        ent_tag    <= Upd_Tag;
        ent_target <= Upd_Target;
        ent_ctr    <= 2'b10;
      end
    end
  end

endmodule

module bp_program_counter #(
  parameter int              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              BTB_DEPTH   = 8,
  parameter int              INSTR_BYTES = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_Target,
  input  logic              Upd_En,
  input  logic [ADDR_W-1:0] Upd_PC,
  input  logic [ADDR_W-1:0] Upd_Target,
  input  logic              Upd_Taken,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PC_Plus_4,
  output logic              Pred_Taken,
  output logic [ADDR_W-1:0] Pred_Target
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int OFF_W = $clog2(INSTR_BYTES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  logic [BTB_DEPTH-1:0]             ent_valid;
  logic [BTB_DEPTH-1:0][TAG_W-1:0]  ent_tag;
  logic [BTB_DEPTH-1:0][ADDR_W-1:0] ent_target;
  logic [BTB_DEPTH-1:0][1:0]        ent_ctr;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit;
  logic [ADDR_W-1:0] pc_nxt;

  // Offset bits below the index are never looked at by the BTB.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Upd_PC, PC};

  assign lk_idx  = PC[OFF_W+IDX_W-1:OFF_W];
  assign lk_tag  = PC[ADDR_W-1:OFF_W+IDX_W];
  assign upd_idx = Upd_PC[OFF_W+IDX_W-1:OFF_W];
  assign upd_tag = Upd_PC[ADDR_W-1:OFF_W+IDX_W];

  genvar g;
  generate
    for (g = 0; g < BTB_DEPTH; g++) begin : g_ent
      bp_program_counter_btb_entry #(
        .ADDR_W (ADDR_W),
        .TAG_W  (TAG_W)
      ) u_ent (
        .CLK        (CLK),
        .Reset      (Reset),
        .Upd_Sel    (Upd_En && (upd_idx == IDX_W'(g))),
        .Upd_Tag    (upd_tag),
        .Upd_Target (Upd_Target),
        .Upd_Taken  (Upd_Taken),
        .ent_valid  (ent_valid[g]),
        .ent_tag    (ent_tag[g]),
        .ent_target (ent_target[g]),
        .ent_ctr    (ent_ctr[g])
      );
    end
  endgenerate

  // Lookup reads pre-edge contents; a same-cycle update is not bypassed.
  assign lk_hit      = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);
  assign Pred_Taken  = lk_hit && ent_ctr[lk_idx][1];
  assign Pred_Target = lk_hit ? ent_target[lk_idx] : '0;
  assign PC_Plus_4   = PC + ADDR_W'(INSTR_BYTES);

  always_comb begin
    pc_nxt = PC_Plus_4;
    if (Redirect)        pc_nxt = Redirect_Target;
    else if (Stall)      pc_nxt = PC;
    else if (Pred_Taken) pc_nxt = Pred_Target;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) PC <= RESET_VEC;
    else        PC <= pc_nxt;
  end

endmodule

// File: tb/tb_bp_program_counter.sv
module tb_bp_program_counter;

  logic        CLK = 1'b0;
  logic        Reset, Stall, Redirect, Upd_En, Upd_Taken;
  logic [31:0] Redirect_Target, Upd_PC, Upd_Target;
  logic [31:0] PC, PC_Plus_4, Pred_Target;
  logic        Pred_Taken;

  int checks = 0;
  int errors = 0;

  bp_program_counter #(
    .ADDR_W      (32),
    .RESET_VEC   (32'h0000_0000),
    .BTB_DEPTH   (8),
    .INSTR_BYTES (4)
  ) dut (
    .CLK             (CLK),
    .Reset           (Reset),
    .Stall           (Stall),
    .Redirect        (Redirect),
    .Redirect_Target (Redirect_Target),
    .Upd_En          (Upd_En),
    .Upd_PC          (Upd_PC),
    .Upd_Target      (Upd_Target),
    .Upd_Taken       (Upd_Taken),
    .PC              (PC),
    .PC_Plus_4       (PC_Plus_4),
    .Pred_Taken      (Pred_Taken),
    .Pred_Target     (Pred_Target)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] redir_tgt;
    logic        upd;
    logic [31:0] upd_pc;
    logic [31:0] upd_tgt;
    logic        upd_tk;
    logic [31:0] exp_pc;
    logic        exp_pt;
    logic [31:0] exp_ptg;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs [NV];

  function automatic vec_t mk(logic st, logic rd, logic [31:0] rt,
                              logic ue, logic [31:0] up, logic [31:0] ut, logic uk,
                              logic [31:0] epc, logic ept, logic [31:0] eptg);
    vec_t v;
    v.stall = st; v.redir = rd; v.redir_tgt = rt;
    v.upd = ue; v.upd_pc = up; v.upd_tgt = ut; v.upd_tk = uk;
    v.exp_pc = epc; v.exp_pt = ept; v.exp_ptg = eptg;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_out(input int idx, input logic [31:0] epc, input logic ept, input logic [31:0] eptg);
    logic [31:0] ep4;
    ep4 = epc + 32'd4;
    chk("pc", idx, PC, epc);
    chk("pc_plus_4", idx, PC_Plus_4, ep4);
    chk("pred_taken", idx, {31'd0, Pred_Taken}, {31'd0, ept});
    chk("pred_target", idx, Pred_Target, eptg);
  endtask

  task automatic idle_inputs();
    Stall = 0; Redirect = 0; Redirect_Target = '0;
    Upd_En = 0; Upd_PC = '0; Upd_Target = '0; Upd_Taken = 0;
  endtask

  task automatic run_vec(input int i);
    Stall = vecs[i].stall; Redirect = vecs[i].redir; Redirect_Target = vecs[i].redir_tgt;
    Upd_En = vecs[i].upd; Upd_PC = vecs[i].upd_pc; Upd_Target = vecs[i].upd_tgt;
    Upd_Taken = vecs[i].upd_tk;
    @(posedge CLK); #1;
    chk_out(i, vecs[i].exp_pc, vecs[i].exp_pt, vecs[i].exp_ptg);
  endtask

  initial begin
    //                st rd  rtgt          ue  upc      utgt     uk   exp_pc        pt  ptg
    // sequential fetch after reset
    vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h4,        0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h8,        0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'hC,        0, 32'h0);
    // train 0x10 taken as fetch arrives there; new entry visible next cycle
    vecs[3]  = mk(0, 0, 32'h0,        1, 32'h10, 32'h40,  1, 32'h10,       1, 32'h40);
    vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h40,       0, 32'h0);
    // two not-taken: 10 -> 01 -> 00, target must stay 0x40
    vecs[5]  = mk(0, 0, 32'h0,        1, 32'h10, 32'h999, 0, 32'h44,       0, 32'h0);
    vecs[6]  = mk(0, 0, 32'h0,        1, 32'h10, 32'h999, 0, 32'h48,       0, 32'h0);
    vecs[7]  = mk(0, 1, 32'h10,       0, 32'h0,  32'h0,   0, 32'h10,       0, 32'h40);
    vecs[8]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h14,       0, 32'h0);
    // four taken: 00->01->10->11->11, then one not-taken -> 10 (taken)
    vecs[9]  = mk(0, 0, 32'h0,        1, 32'h10, 32'h40,  1, 32'h18,       0, 32'h0);
    vecs[10] = mk(0, 0, 32'h0,        1, 32'h10, 32'h40,  1, 32'h1C,       0, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,        1, 32'h10, 32'h40,  1, 32'h20,       0, 32'h0);
    vecs[12] = mk(0, 0, 32'h0,        1, 32'h10, 32'h40,  1, 32'h24,       0, 32'h0);
    vecs[13] = mk(0, 0, 32'h0,        1, 32'h10, 32'h999, 0, 32'h28,       0, 32'h0);
    vecs[14] = mk(0, 1, 32'h10,       0, 32'h0,  32'h0,   0, 32'h10,       1, 32'h40);
    vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h40,       0, 32'h0);
    // alias 0x30 onto index 4 replaces 0x10
    vecs[16] = mk(0, 0, 32'h0,        1, 32'h30, 32'h80,  1, 32'h44,       0, 32'h0);
    vecs[17] = mk(0, 1, 32'h10,       0, 32'h0,  32'h0,   0, 32'h10,       0, 32'h0);
    vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h14,       0, 32'h0);
    vecs[19] = mk(0, 1, 32'h30,       0, 32'h0,  32'h0,   0, 32'h30,       1, 32'h80);
    vecs[20] = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h80,       0, 32'h0);
    // update of the PC being fetched: decision uses old (miss) contents
    vecs[21] = mk(0, 0, 32'h0,        1, 32'h80, 32'h200, 1, 32'h84,       0, 32'h0);
    vecs[22] = mk(0, 1, 32'h80,       0, 32'h0,  32'h0,   0, 32'h80,       1, 32'h200);
    vecs[23] = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h200,      0, 32'h0);
    // redirect beats stall; training still happens while stalled
    vecs[24] = mk(1, 1, 32'h100,      0, 32'h0,  32'h0,   0, 32'h100,      0, 32'h0);
    vecs[25] = mk(1, 0, 32'h0,        1, 32'h100,32'h300, 1, 32'h100,      1, 32'h300);
    vecs[26] = mk(1, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h100,      1, 32'h300);
    vecs[27] = mk(1, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h100,      1, 32'h300);
    vecs[28] = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h300,      0, 32'h0);
    // wrap-around at top of address space
    vecs[29] = mk(0, 1, 32'hFFFF_FFFC,0, 32'h0,  32'h0,   0, 32'hFFFF_FFFC,0, 32'h0);
    vecs[30] = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h0,        0, 32'h0);
    vecs[31] = mk(0, 1, 32'h200,      0, 32'h0,  32'h0,   0, 32'h200,      0, 32'h0);
    // after async reset: nothing trained earlier predicts
    vecs[32] = mk(0, 1, 32'h30,       0, 32'h0,  32'h0,   0, 32'h30,       0, 32'h0);
    vecs[33] = mk(0, 1, 32'h100,      0, 32'h0,  32'h0,   0, 32'h100,      0, 32'h0);
    vecs[34] = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h104,      0, 32'h0);
    vecs[35] = mk(0, 1, 32'h10,       0, 32'h0,  32'h0,   0, 32'h10,       0, 32'h0);

    idle_inputs();
    Reset = 0;
    @(posedge CLK); #1;
    chk_out(-1, 32'h0, 1'b0, 32'h0);
    Reset = 1;

    for (int i = 0; i < 32; i++) run_vec(i);

    // async reset mid-cycle at PC=0x200 with a trained BTB; competing
    // redirect/update while held in reset must have no effect
    #2;
    Reset = 0;
    Redirect = 1; Redirect_Target = 32'h500;
    Upd_En = 1; Upd_PC = 32'h30; Upd_Target = 32'h80; Upd_Taken = 1;
    #1;
    chk_out(-2, 32'h0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    chk_out(-3, 32'h0, 1'b0, 32'h0);
    idle_inputs();
    Reset = 1;

    for (int i = 32; i < NV; i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
